// File: rtl/uart_buffered_tx_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encodings
// and the baud divider calculation, also used by the receiver side.
package uart_buffered_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: dout always shows the head word.
// full/empty come from the occupancy count; pointers wrap modulo DEPTH.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_wr;
  logic              w_do_rd;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign dout    = r_mem[r_rd_ptr];
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;

  // Storage has no reset so it can map onto plain RAM; only pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 transmitter: bytes are queued in a FIFO and serialised LSB first
// on RsTx; back-to-back bytes produce contiguous frames with no idle gap.
module uart_buffered_tx
  import uart_buffered_tx_pkg::*;
#(
  parameter int CLK_RATE   = 9600000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic                         RsTx,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [1:0]        r_state;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_overflow;

  logic [7:0]        w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_wr;
  logic              w_pop;
  logic              w_bit_end;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (w_wr),
    .din   (din),
    .rd_en (w_pop),
    .dout  (w_fifo_dout),
    .count (fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign din_ready = !w_fifo_full;
  assign w_wr      = din_valid && din_ready;
  assign w_bit_end = (r_baud_cnt == BAUD_LAST);
  // Pop either from idle or on the final stop-bit cycle, so the next start bit follows directly.
  assign w_pop     = !w_fifo_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
  assign RsTx      = r_tx;
  assign tx_busy   = (r_state != ST_IDLE);
  assign overflow  = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (din_valid && !din_ready) r_overflow <= 1'b1;

      if ((r_state == ST_IDLE) || w_bit_end) r_baud_cnt <= '0;
      else                                   r_baud_cnt <= r_baud_cnt + BAUD_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_fifo_dout;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
